// File: rtl/br_pred_ctrl.sv
// Next-PC controller: direct-mapped BTB with 2-bit counters, verified at decode (direct J/CALL)
// and at execute (resolved outcome), with redirect/squash generation and a mispredict counter.
module br_pred_ctrl #(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned IDX_W    = 3,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int unsigned MISP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   i_pc_fetch,
  input  logic              i_fetch_valid,
  input  logic              i_stall,
  input  logic              i_dec_valid,
  input  logic              i_dec_direct,
  input  logic [PC_W-1:0]   i_dec_offset,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_br,
  input  logic              i_ex_taken,
  input  logic [PC_W-1:0]   i_ex_target,
  output logic [PC_W-1:0]   o_pc_addr,
  output logic              o_pred_taken,
  output logic              o_squash_fetch,
  output logic              o_squash_dec,
  output logic [MISP_W-1:0] o_misp_cnt
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned TagW  = PC_W - IDX_W;

  logic [Depth-1:0] btb_valid_q;
  logic [TagW-1:0]  btb_tag_q [Depth];
  logic [PC_W-1:0]  btb_tgt_q [Depth];
  logic [1:0]       btb_cnt_q [Depth];

  logic [PC_W-1:0]   dec_pc_q, dec_pred_q, ex_pc_q, ex_pred_q;
  logic              dec_valid_q, ex_valid_q;
  logic [MISP_W-1:0] misp_q;

  logic [IDX_W-1:0] f_idx, x_idx;
  logic [TagW-1:0]  f_tag, x_tag;
  logic             f_hit, x_hit, pred_taken, dec_misp, ex_misp, btb_upd;
  logic [PC_W-1:0]  pred_pc, dec_tgt, ex_act;

  always_comb begin
    f_idx      = i_pc_fetch[IDX_W-1:0];
    f_tag      = i_pc_fetch[PC_W-1:IDX_W];
    f_hit      = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    pred_taken = i_fetch_valid && f_hit && btb_cnt_q[f_idx][1];
    pred_pc    = pred_taken ? btb_tgt_q[f_idx] : i_pc_fetch + PC_W'(1);

    dec_tgt  = dec_pc_q + PC_W'(1) + i_dec_offset;
    dec_misp = !i_stall && i_dec_valid && dec_valid_q && i_dec_direct && (dec_pred_q != dec_tgt);

    ex_act  = (i_ex_is_br && i_ex_taken) ? i_ex_target : ex_pc_q + PC_W'(1);
    ex_misp = !i_stall && i_ex_valid && ex_valid_q && (ex_pred_q != ex_act);

    x_idx   = ex_pc_q[IDX_W-1:0];
    x_tag   = ex_pc_q[PC_W-1:IDX_W];
    x_hit   = btb_valid_q[x_idx] && (btb_tag_q[x_idx] == x_tag);
    btb_upd = !i_stall && i_ex_valid && ex_valid_q && i_ex_is_br;
  end

  always_comb begin
    o_pc_addr      = pred_pc;
    o_pred_taken   = pred_taken;
    o_squash_fetch = 1'b0;
    o_squash_dec   = 1'b0;
    o_misp_cnt     = misp_q;
    if (ex_misp) begin
      o_pc_addr      = ex_act;
      o_squash_fetch = 1'b1;
      o_squash_dec   = 1'b1;
    end else if (dec_misp) begin
      o_pc_addr      = dec_tgt;
      o_squash_fetch = 1'b1;
    end
  end

  // Stage registers; a decode redirect becomes the prediction the instruction carries onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_pc_q    <= '0;
      dec_pred_q  <= '0;
      dec_valid_q <= 1'b0;
      ex_pc_q     <= '0;
      ex_pred_q   <= '0;
      ex_valid_q  <= 1'b0;
      misp_q      <= '0;
    end else if (!i_stall) begin
      dec_pc_q    <= i_pc_fetch;
      dec_pred_q  <= pred_pc;
      dec_valid_q <= i_fetch_valid && !o_squash_fetch;
      ex_pc_q     <= dec_pc_q;
      ex_pred_q   <= dec_misp ? dec_tgt : dec_pred_q;
      ex_valid_q  <= dec_valid_q && !o_squash_dec;
      if (ex_misp && (misp_q != '1)) begin
        misp_q <= misp_q + MISP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btb_valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_cnt_q[i] <= CNT_INIT;
      end
    end else if (btb_upd) begin
      if (i_ex_taken) begin
        btb_valid_q[x_idx] <= 1'b1;
        btb_tag_q[x_idx]   <= x_tag;
        btb_tgt_q[x_idx]   <= i_ex_target;
        if (!x_hit) begin
          btb_cnt_q[x_idx] <= 2'b10;
        end else if (btb_cnt_q[x_idx] != 2'b11) begin
          btb_cnt_q[x_idx] <= btb_cnt_q[x_idx] + 2'b01;
        end
      end else if (x_hit && (btb_cnt_q[x_idx] != 2'b00)) begin
        btb_cnt_q[x_idx] <= btb_cnt_q[x_idx] - 2'b01;
      end
    end
  end

endmodule
